univ_shift_reg: RTL and testbench

Parametrised universal shift register: the multi-bit, multi-mode successor to the single D flip-flop exercised in the lab-5 benches. It holds a WIDTH-bit word and, on each enabled rising CLK, holds, loads, shifts, rotates, or counts according to MODE. It provides a serial-out bit, a wrap/carry flag, and a zero flag. It is the storage element for later lab exercises: serial links, counters, and LFSR seeds.

---
 rtl/univ_shift_reg_pkg.sv | 24 ++
 rtl/usr_next.sv | 55 +++++
 rtl/univ_shift_reg.sv | 59 +++++
 tb/tb_univ_shift_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register family.
// The mode encodings are reused by the counter and LFSR blocks.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    USR_HOLD = 3'd0,
    USR_LOAD = 3'd1,
    USR_SHL  = 3'd2,
    USR_SHR  = 3'd3,
    USR_ROL  = 3'd4,
    USR_ROR  = 3'd5,
    USR_INC  = 3'd6,
    USR_DEC  = 3'd7
  } usr_mode_e;

  localparam int USR_WIDTH_MIN = 2;
  localparam int USR_WIDTH_MAX = 32;

  // True for the two modes that move a bit out through SO.
  function automatic logic usr_is_shift(input usr_mode_e m);
    return (m == USR_SHL) || (m == USR_SHR);
  endfunction

endpackage

// File: rtl/usr_next.sv
// Combinational next-state logic for univ_shift_reg: computes the word,
// serial-out bit and wrap flag that the register bank captures.
module usr_next
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             so,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] next_q,
  output logic             next_so,
  output logic             next_carry
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  usr_mode_e op;
  logic      shift_out;

  assign op = usr_mode_e'(mode);

  // The bit leaving the word: MSB for left shifts, LSB for right shifts.
  assign shift_out = (op == USR_SHL) ? q[WIDTH-1] : q[0];

  always_comb begin
    next_q     = q;
    next_carry = 1'b0;
    case (op)
      USR_HOLD: next_q = q;
      USR_LOAD: next_q = d;
      USR_SHL:  next_q = {q[WIDTH-2:0], si};
      USR_SHR:  next_q = {si, q[WIDTH-1:1]};
      USR_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      USR_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      USR_INC: begin
        next_q     = q + ONE;
        next_carry = (q == ALL_ONES);
      end
      USR_DEC: begin
        next_q     = q - ONE;
        next_carry = (q == ALL_ZERO);
      end
      default: next_q = q;
    endcase
  end

  // SO is sticky: only the two shift modes replace it.
  assign next_so = usr_is_shift(op) ? shift_out : so;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/count on each enabled
// rising edge, with serial-out, wrap flag and combinational zero flag.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             CARRY,
  output logic             ZERO
);

  generate
    if (WIDTH < USR_WIDTH_MIN || WIDTH > USR_WIDTH_MAX) begin : g_width_check
      $error("univ_shift_reg: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] next_q;
  logic             next_so;
  logic             next_carry;

  usr_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q          (Q),
    .so         (SO),
    .mode       (MODE),
    .d          (D),
    .si         (SI),
    .next_q     (next_q),
    .next_so    (next_so),
    .next_carry (next_carry)
  );

  // Single register bank; EN low freezes Q, SO and CARRY together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q     <= RESET_VAL;
      SO    <= 1'b0;
      CARRY <= 1'b0;
    end else if (EN) begin
      Q     <= next_q;
      SO    <= next_so;
      CARRY <= next_carry;
    end
  end

  assign ZERO = (Q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at widths 8, 2 and 32; the driver queues
// hand-computed results and a monitor checks them after each rising edge.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic        CLK;
  logic        RST;
  logic        en8, en2, en32;
  logic [2:0]  mode;
  logic [31:0] d;
  logic        si;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [31:0] q32;
  logic        so8, so2, so32;
  logic        c8, c2, c32;
  logic        z8, z2, z32;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .CLK(CLK), .RST(RST), .EN(en8), .MODE(mode), .D(d[7:0]), .SI(si),
    .Q(q8), .SO(so8), .CARRY(c8), .ZERO(z8)
  );

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'd1)) dut2 (
    .CLK(CLK), .RST(RST), .EN(en2), .MODE(mode), .D(d[1:0]), .SI(si),
    .Q(q2), .SO(so2), .CARRY(c2), .ZERO(z2)
  );

  univ_shift_reg #(.WIDTH(32), .RESET_VAL(32'd1)) dut32 (
    .CLK(CLK), .RST(RST), .EN(en32), .MODE(mode), .D(d), .SI(si),
    .Q(q32), .SO(so32), .CARRY(c32), .ZERO(z32)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard entry: which DUT, and its required outputs after the edge.
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] q;
    logic        so;
    logic        carry;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  localparam logic [1:0] S8 = 2'd0, S2 = 2'd1, S32 = 2'd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input logic [1:0] sel, input string tag, input exp_t e);
    logic [31:0] aq;
    logic        aso, ac, az;
    string       pfx;
    case (sel)
      S8:      begin aq = {24'd0, q8}; aso = so8;  ac = c8;  az = z8;  pfx = "w8";  end
      S2:      begin aq = {30'd0, q2}; aso = so2;  ac = c2;  az = z2;  pfx = "w2";  end
      default: begin aq = q32;         aso = so32; ac = c32; az = z32; pfx = "w32"; end
    endcase
    check({pfx, "_", tag, "_q"},     aq,           e.q);
    check({pfx, "_", tag, "_so"},    {31'd0, aso}, {31'd0, e.so});
    check({pfx, "_", tag, "_carry"}, {31'd0, ac},  {31'd0, e.carry});
    check({pfx, "_", tag, "_zero"},  {31'd0, az},  {31'd0, e.zero});
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e = '{sel: S8, q: 32'h0, so: 1'b0, carry: 1'b0, zero: 1'b1};
    check_dut(S8, tag, e);
    e = '{sel: S2, q: 32'h1, so: 1'b0, carry: 1'b0, zero: 1'b0};
    check_dut(S2, tag, e);
    e = '{sel: S32, q: 32'h1, so: 1'b0, carry: 1'b0, zero: 1'b0};
    check_dut(S32, tag, e);
  endtask

  // driver: inputs change on the falling edge, result checked after the next rising edge
  task automatic step(input logic [1:0] sel, input logic e, input usr_mode_e m,
                      input logic [31:0] dv, input logic s, input logic [31:0] eq,
                      input logic eso, input logic ec, input logic ez);
    exp_t x;
    @(negedge CLK);
    en8  = (sel == S8)  && e;
    en2  = (sel == S2)  && e;
    en32 = (sel == S32) && e;
    mode = m;
    d    = dv;
    si   = s;
    x = '{sel: sel, q: eq, so: eso, carry: ec, zero: ez};
    exp_q.push_back(x);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_dut(e.sel, "seq", e);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST  = 1'b1;
    en8  = 1'b0;
    en2  = 1'b0;
    en32 = 1'b0;
    mode = 3'd0;
    d    = 32'd0;
    si   = 1'b0;

    #3  check_reset("rst_early");
    #19 check_reset("rst_late");
    #5  RST = 1'b0;

    // load, then disabled INC must not move anything
    step(S8, 1, USR_LOAD, 32'hA5, 0, 32'hA5, 0, 0, 0);
    step(S8, 0, USR_INC,  32'h00, 0, 32'hA5, 0, 0, 0);
    step(S8, 0, USR_INC,  32'h00, 0, 32'hA5, 0, 0, 0);
    step(S8, 0, USR_INC,  32'h00, 0, 32'hA5, 0, 0, 0);
    // shifts and rotate
    step(S8, 1, USR_SHL,  32'h00, 1, 32'h4B, 1, 0, 0);
    step(S8, 1, USR_SHR,  32'h00, 0, 32'h25, 1, 0, 0);
    step(S8, 1, USR_ROL,  32'h00, 0, 32'h4A, 1, 0, 0);
    // counter wrap
    step(S8, 1, USR_LOAD, 32'hFE, 0, 32'hFE, 1, 0, 0);
    step(S8, 1, USR_INC,  32'h00, 0, 32'hFF, 1, 0, 0);
    step(S8, 1, USR_INC,  32'h00, 0, 32'h00, 1, 1, 1);
    step(S8, 1, USR_DEC,  32'h00, 0, 32'hFF, 1, 1, 0);
    step(S8, 1, USR_HOLD, 32'h00, 0, 32'hFF, 1, 0, 0);
    // full rotate circle; SI toggled to show it is ignored
    step(S8, 1, USR_LOAD, 32'h81, 0, 32'h81, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 0, 32'hC0, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 1, 32'h60, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 0, 32'h30, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 1, 32'h18, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 0, 32'h0C, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 1, 32'h06, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 0, 32'h03, 1, 0, 0);
    step(S8, 1, USR_ROR,  32'h00, 1, 32'h81, 1, 0, 0);
    step(S8, 0, USR_HOLD, 32'h00, 0, 32'h81, 1, 0, 0);

    // mid-cycle reset clears immediately, then the next edge acts on RESET_VAL
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_reset("rst_mid");
    #1 RST = 1'b0;
    step(S8, 1, USR_INC,  32'h00, 0, 32'h01, 0, 0, 0);

    // width 2 wrap at 3
    step(S2, 1, USR_LOAD, 32'h2, 0, 32'h2, 0, 0, 0);
    step(S2, 1, USR_INC,  32'h0, 0, 32'h3, 0, 0, 0);
    step(S2, 1, USR_INC,  32'h0, 0, 32'h0, 0, 1, 1);
    step(S2, 1, USR_DEC,  32'h0, 0, 32'h3, 0, 1, 0);
    step(S2, 1, USR_HOLD, 32'h0, 0, 32'h3, 0, 0, 0);
    step(S2, 1, USR_SHL,  32'h0, 0, 32'h2, 1, 0, 0);
    step(S2, 0, USR_DEC,  32'h0, 0, 32'h2, 1, 0, 0);

    // width 32 wrap at all-ones
    step(S32, 1, USR_LOAD, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0, 0, 0);
    step(S32, 1, USR_INC,  32'h0,         0, 32'hFFFF_FFFF, 0, 0, 0);
    step(S32, 1, USR_INC,  32'h0,         0, 32'h0000_0000, 0, 1, 1);
    step(S32, 1, USR_DEC,  32'h0,         0, 32'hFFFF_FFFF, 0, 1, 0);
    step(S32, 1, USR_HOLD, 32'h0,         0, 32'hFFFF_FFFF, 0, 0, 0);
    step(S32, 1, USR_SHR,  32'h0,         0, 32'h7FFF_FFFF, 1, 0, 0);
    step(S32, 0, USR_INC,  32'h0,         0, 32'h7FFF_FFFF, 1, 0, 0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
